// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Bit counter width; a 1-bit input still needs a 1-bit counter.
    function automatic int bcd_cnt_w(input int bin_w);
        return ($clog2(bin_w) > 0) ? $clog2(bin_w) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Add-3 correction for one BCD digit ahead of the left shift.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH)
            dout = din + BCD_ADJ_ADD;
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock; BCD_SEQ_BLANK_EN adds a leading-zero mask.
// Latency: BIN_W cycles accept-to-out_valid, one result per BIN_W+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the output handshake.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      binary,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = bcd_cnt_w(BIN_W);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [BIN_W-1:0]     shreg;
    logic [4*DIGITS-1:0]  dig;
    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  dig_nxt;
    logic                 ovf_nxt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (dig[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    // The digit chain and shift register move as one wide left shift;
    // whatever falls off the top digit is a lost decimal carry.
    always_comb begin
        dig_nxt = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
        ovf_nxt = ovf | adj[4*DIGITS-1];
    end

`ifdef BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_run;

    // Walk down from the top digit; a digit blanks only while everything above it is zero.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (dig_nxt[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_run && !ovf_nxt;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            shreg     <= '0;
            dig       <= '0;
            ovf       <= 1'b0;
`ifdef BCD_SEQ_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg    <= binary;
                        dig      <= '0;
                        ovf      <= 1'b0;
                        count    <= CNT_W'(BIN_W - 1);
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
`ifdef BCD_SEQ_BLANK_EN
                        blank_q  <= '0;
`endif
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg << 1;
                    dig   <= dig_nxt;
                    ovf   <= ovf_nxt;
                    if (count == '0) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
`ifdef BCD_SEQ_BLANK_EN
                        blank_q   <= blank_nxt;
`endif
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd = dig;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed and swept checks of bcd_seq_conv at 4 and 3 digits, both instances driven in lockstep.
module tb_bcd_seq_conv;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [9:0]  binary;
    logic        out_ready;

    logic        in_ready4, out_valid4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;
    logic        in_ready3, out_valid3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    int total = 0;
    int bad   = 0;

    bcd_seq_conv #(.BIN_W(10), .DIGITS(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .binary    (binary),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .bcd       (bcd4),
        .ovf       (ovf4),
        .blank     (blank4)
    );

    bcd_seq_conv #(.BIN_W(10), .DIGITS(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .binary    (binary),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .bcd       (bcd3),
        .ovf       (ovf3),
        .blank     (blank3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_bcd(input int v, input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] model_blank(input int v, input int d);
        logic [31:0] r;
        r = '0;
`ifdef BCD_SEQ_BLANK_EN
        if (v < pow10(d))
            for (int k = 1; k < d; k++) r[k] = (v < pow10(k));
`endif
        return r;
    endfunction

    // Each step starts and ends 1 time unit after a rising edge.
    task automatic start(input logic [9:0] v);
        int n;
        n = 0;
        while (!in_ready4 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready4 & in_ready3), 32'd1);
        in_valid = 1'b1;
        binary   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid4 && lat < 40);
        chk("latency", 32'(lat), 32'd10);
        chk("out_valid3", 32'(out_valid3), 32'd1);
    endtask

    task automatic check_res(input string tag,
                             input logic [15:0] e_bcd4, input logic e_ovf4, input logic [3:0] e_blank4,
                             input logic [11:0] e_bcd3, input logic e_ovf3, input logic [2:0] e_blank3);
        logic [3:0] b4;
        logic [2:0] b3;
`ifdef BCD_SEQ_BLANK_EN
        b4 = e_blank4;
        b3 = e_blank3;
`else
        b4 = 4'd0;
        b3 = 3'd0;
`endif
        chk({tag, "_bcd4"},   32'(bcd4),   32'(e_bcd4));
        chk({tag, "_ovf4"},   32'(ovf4),   32'(e_ovf4));
        chk({tag, "_blank4"}, 32'(blank4), 32'(b4));
        chk({tag, "_bcd3"},   32'(bcd3),   32'(e_bcd3));
        chk({tag, "_ovf3"},   32'(ovf3),   32'(e_ovf3));
        chk({tag, "_blank3"}, 32'(blank3), 32'(b3));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid4 | out_valid3), 32'd0);
        chk("in_ready_after_hs",  32'(in_ready4 & in_ready3),  32'd1);
    endtask

    initial begin
        logic ovf_seen;
        logic stable;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        binary    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready4),  32'd1);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_bcd",       32'(bcd4),       32'd0);
        chk("rst_ovf",       32'(ovf4),       32'd0);
        chk("rst_blank",     32'(blank4),     32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted mid-conversion
        start(10'd300);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(in_ready4),  32'd1);
        chk("midrst_out_valid", 32'(out_valid4), 32'd0);
        chk("midrst_bcd",       32'(bcd4),       32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready4), 32'd1);
        chk("post_rst_ovf",      32'(ovf4),      32'd0);
        chk("post_rst_blank",    32'(blank4),    32'd0);
        ovf_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            ovf_seen = ovf_seen | out_valid4;
        end
        chk("post_rst_no_result", 32'(ovf_seen), 32'd0);

        start(10'd999);
        wait_done();
        check_res("v999", 16'h0999, 1'b0, 4'b1000, 12'h999, 1'b0, 3'b000);
        handshake();

        start(10'd1023);
        wait_done();
        check_res("v1023", 16'h1023, 1'b0, 4'b0000, 12'h023, 1'b1, 3'b000);
        handshake();

        // Held output under backpressure, with an ignored new request
        start(10'd512);
        wait_done();
        check_res("v512", 16'h0512, 1'b0, 4'b1000, 12'h512, 1'b0, 3'b000);
        in_valid = 1'b1;
        binary   = 10'd7;
        stable   = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bcd4 !== 16'h0512 || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        in_valid = 1'b0;
        handshake();
        chk("bcd_kept_after_hs", 32'(bcd4), 32'h0512);

        start(10'd0);
        wait_done();
        check_res("v0", 16'h0000, 1'b0, 4'b1110, 12'h000, 1'b0, 3'b110);
        handshake();

        start(10'd1000);
        wait_done();
        check_res("v1000", 16'h1000, 1'b0, 4'b0000, 12'h000, 1'b1, 3'b000);
        handshake();

        start(10'd7);
        wait_done();
        check_res("v7", 16'h0007, 1'b0, 4'b1110, 12'h007, 1'b0, 3'b110);
        handshake();

        for (int v = 0; v < 1024; v++) begin
            start(10'(v));
            wait_done();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check_res("sweep",
                      16'(model_bcd(v, 4)), 1'b0,                 4'(model_blank(v, 4)),
                      12'(model_bcd(v, 3)), (v >= pow10(3)),      3'(model_blank(v, 3)));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
